run_len_detector: RTL and testbench
===================================

Name: run_len_detector

Overview:
- Parametrised consecutive-run detector. Asserts a detect level once RUN_LEN consecutive enabled samples of `ina` equal the selected polarity. Holds it until the run breaks.
- Adds a sample enable, polarity select, a one-cycle detect pulse with an optional periodic retrigger mode, and a saturating run-length count.
- Sits on a serial input line ahead of control logic that needs debounced or run-qualified events.

Parameters:
- RUN_LEN, 3, consecutive matching samples required for detection; legal range 2..(2**CNT_W-1).
- CNT_W, 4, width of the run_cnt output and the internal run counter.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; when 0, all state, counters and outputs hold, and det_pulse is 0.
- ina  input  1  serial data sample.
- polarity  input  1  level to match: 1 = runs of ones, 0 = runs of zeros. Sampled together with ina.
- retrig  input  1  0 = single pulse per run; 1 = pulse repeats every RUN_LEN further matches while the run continues.
- dataout  output  1  detect level; high while state is HIT.
- det_pulse  output  1  registered one-cycle detect strobe.
- run_cnt  output  CNT_W  consecutive matching samples so far; saturates at 2**CNT_W-1.
- state_o  output  2  current state encoding, for debug.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, run counter=0, phase counter=0, dataout=0, det_pulse=0, run_cnt=0. Reset wins over everything, including mid-run. On release, the first enabled edge is treated as sample 1.
- Match definition: `match = (ina == polarity)`, evaluated only on edges where en=1. A polarity change mid-run is just a mismatch or match under the new polarity; there is no special handling.
- States (Gray-coded): IDLE=2'b00, ACC=2'b01, HIT=2'b11. Code 2'b10 is illegal and goes to IDLE on the next enabled edge.
- Transitions, enabled edge only:
  - IDLE: match -> ACC, cnt=1; no match -> stay in IDLE.
  - ACC: no match -> IDLE, cnt=0. Match with cnt+1 == RUN_LEN -> HIT. Otherwise stay in ACC and increment cnt.
  - HIT: match -> stay in HIT, cnt increments with saturation; no match -> IDLE, cnt=0.
- dataout: combinational decode of state==HIT. It rises on the same edge that captures the RUN_LEN-th match, so latency is 0 cycles after that edge. It falls on the edge capturing the first mismatch.
- det_pulse: registered; high for exactly one cycle after the edge entering HIT.
  - With retrig=1, a phase counter (modulo RUN_LEN) runs while in HIT. det_pulse also fires on every RUN_LEN-th further match, i.e. at match counts 2·RUN_LEN, 3·RUN_LEN, and so on.
  - The phase counter clears on entry to HIT and on any exit.
  - retrig is sampled every edge; a change mid-run takes effect from the next match.
- run_cnt: mirrors the run counter. It saturates at 2**CNT_W-1 and does not wrap. Saturation does not stop retrigger pulses, because the phase counter is independent.
- en=0 for any duration: no state change, no pulse, and the run is neither broken nor advanced (samples are skipped, not counted as mismatches).
- Simultaneous rst deassert and a match: the sample is counted, since reset is async and the edge sees rst=1.

Optional Feature:
- Macro RUN_DET_STICKY_EN.
- When defined, adds two ports:
  - sticky_clr (input, 1): synchronous clear.
  - sticky (output, 1): registered; set on any det_pulse; cleared on reset, or by sticky_clr when no det_pulse occurs in the same cycle (set wins over clear).
- When undefined, neither port nor its flop exists; all other behaviour is identical.

Decomposition:
- Package run_len_pkg: state typedef/localparams IDLE, ACC, HIT (2-bit Gray), and the illegal code constant.
- One natural sub-module, sat_counter: CNT_W-wide saturating up-counter with sync clear and enable, used for run_cnt. The phase counter stays inline.

Test Plan:
- RUN_LEN=3, polarity=1, en=1, ina=1,1,1,1,0 -> dataout 0,0,1,1,0. det_pulse high only in the cycle after the 3rd sample. run_cnt 1,2,3,4,0.
- ina=1,1,0,1,1,1 -> no detect after the first two samples, run_cnt returns to 0. Detect on the 6th sample.
- polarity=0, ina=0,0,0 -> dataout=1 after the 3rd sample. Then polarity=1 with ina=0 -> IDLE, dataout=0.
- retrig=1, ina=1 for 10 samples -> det_pulse after samples 3, 6 and 9 only. With CNT_W=3, run_cnt saturates at 7.
- en toggled 1,0,0,1,0,1 with ina=1 held -> detect on the 3rd enabled sample; state holds during en=0.
- Reset asserted mid-HIT -> dataout, det_pulse and run_cnt go to 0 immediately, without waiting for a clock edge. With RUN_DET_STICKY_EN defined: sticky=1 after a detect, and sticky_clr clears it.

Source files
------------

// File: rtl/run_len_pkg.sv
// rtl/run_len_pkg.sv - state encoding shared by the run-length detector files
package run_len_pkg;

  // Gray-coded so that IDLE->ACC->HIT each flip a single bit
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    HIT  = 2'b11
  } state_t;

  localparam logic [1:0] ILLEGAL_CODE = 2'b10;

endpackage

// File: rtl/run_len_detector_if.sv
// rtl/run_len_detector_if.sv - sample/detect bundle; RUN_DET_STICKY_EN adds sticky_clr/sticky
interface run_len_detector_if #(
  parameter int CNT_W = 4
);

  logic             en;
  logic             ina;
  logic             polarity;
  logic             retrig;
  logic             dataout;
  logic             det_pulse;
  logic [CNT_W-1:0] run_cnt;
  logic [1:0]       state_o;
`ifdef RUN_DET_STICKY_EN
  logic             sticky_clr;
  logic             sticky;

  modport master (
    output en, ina, polarity, retrig, sticky_clr,
    input  dataout, det_pulse, run_cnt, state_o, sticky
  );

  modport slave (
    input  en, ina, polarity, retrig, sticky_clr,
    output dataout, det_pulse, run_cnt, state_o, sticky
  );
`else
  modport master (
    output en, ina, polarity, retrig,
    input  dataout, det_pulse, run_cnt, state_o
  );

  modport slave (
    input  en, ina, polarity, retrig,
    output dataout, det_pulse, run_cnt, state_o
  );
`endif

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - W-bit up-counter that sticks at all-ones, sync clear has priority
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/run_len_detector.sv
// rtl/run_len_detector.sv - consecutive-run detector with retrigger pulse; RUN_DET_STICKY_EN adds sticky flag
module run_len_detector
  import run_len_pkg::*;
#(
  parameter int RUN_LEN = 3,
  parameter int CNT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  run_len_detector_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(RUN_LEN - 1);
  localparam logic [CNT_W:0]   RUN_LEN_W  = (CNT_W + 1)'(RUN_LEN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             det_q, det_d;
  logic             cnt_clr, cnt_inc;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W:0]   next_cnt;
  logic             match;

  assign match    = (bus.ina == bus.polarity);
  assign next_cnt = {1'b0, run_cnt} + 1'b1;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    det_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (match) begin
            state_d = ACC;
            cnt_inc = 1'b1;
          end
        end
        ACC: begin
          if (!match) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            if (next_cnt == RUN_LEN_W) begin
              state_d = HIT;
              det_d   = 1'b1;
              phase_d = '0;
            end
          end
        end
        HIT: begin
          if (!match) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
            phase_d = '0;
          end else begin
            cnt_inc = 1'b1;
            // Phase runs independently of run_cnt so retrigger survives saturation
            if (phase_q == LAST_PHASE) begin
              phase_d = '0;
              det_d   = bus.retrig;
            end else begin
              phase_d = phase_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_clr = 1'b1;
          phase_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      det_q   <= det_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (run_cnt)
  );

  assign bus.dataout   = (state_q == HIT);
  assign bus.det_pulse = det_q;
  assign bus.run_cnt   = run_cnt;
  assign bus.state_o   = state_q;

`ifdef RUN_DET_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= det_q | (sticky_q & ~bus.sticky_clr);
    end
  end

  assign bus.sticky = sticky_q;
`endif

endmodule

// File: tb/tb_run_len_detector.sv
// tb/tb_run_len_detector.sv - vector table, corner sequences and random run model for run_len_detector
module tb_run_len_detector;

  localparam int RUN_LEN = 3;
  localparam int CNT_W   = 3;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  run_len_detector_if #(.CNT_W(CNT_W)) bus ();

  run_len_detector #(.RUN_LEN(RUN_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit en;
    bit ina;
    bit pol;
    bit rt;
    bit d;
    bit p;
    int c;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: the run is just an unbounded count of consecutive matches
  int   m_run = 0;
  bit   m_det = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input bit en, input bit ina, input bit pol, input bit rt,
                     input bit d, input bit p, input int c);
    vec_t v;
    v.en = en; v.ina = ina; v.pol = pol; v.rt = rt; v.d = d; v.p = p; v.c = c;
    vecs.push_back(v);
  endtask

  task automatic model_step(input bit en, input bit ina, input bit pol, input bit rt);
    bit m;
    m_det = 1'b0;
    if (en) begin
      m = (ina == pol);
      m_run = m ? m_run + 1 : 0;
      m_det = m && (m_run >= RUN_LEN) &&
              ((m_run == RUN_LEN) || (rt && (m_run % RUN_LEN == 0)));
    end
  endtask

  task automatic apply(input bit en, input bit ina, input bit pol, input bit rt);
    bus.en = en; bus.ina = ina; bus.polarity = pol; bus.retrig = rt;
    @(posedge clk);
    #1;
    model_step(en, ina, pol, rt);
  endtask

  task automatic check_model(input string tag);
    int exp_cnt;
    int exp_st;
    exp_cnt = (m_run > SAT) ? SAT : m_run;
    exp_st  = (m_run == 0) ? 0 : ((m_run < RUN_LEN) ? 1 : 3);
    check({tag, "_dataout"}, bus.dataout, (m_run >= RUN_LEN) ? 1 : 0);
    check({tag, "_det"}, bus.det_pulse, m_det);
    check({tag, "_cnt"}, bus.run_cnt, exp_cnt);
    check({tag, "_state"}, bus.state_o, exp_st);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_run = 0;
    m_det = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bit ina_r, pol_r, rt_r, en_r;

    bus.en = 1'b0; bus.ina = 1'b0; bus.polarity = 1'b1; bus.retrig = 1'b0;
`ifdef RUN_DET_STICKY_EN
    bus.sticky_clr = 1'b0;
`endif
    do_reset();
    check("reset_dataout", bus.dataout, 0);
    check("reset_det", bus.det_pulse, 0);
    check("reset_cnt", bus.run_cnt, 0);
    check("reset_state", bus.state_o, 0);

    // basic run of ones, then break
    add(1,1,1,0, 0,0,1); add(1,1,1,0, 0,0,2); add(1,1,1,0, 1,1,3);
    add(1,1,1,0, 1,0,4); add(1,0,1,0, 0,0,0);
    // short run broken, then a full run
    add(1,1,1,0, 0,0,1); add(1,1,1,0, 0,0,2); add(1,0,1,0, 0,0,0);
    add(1,1,1,0, 0,0,1); add(1,1,1,0, 0,0,2); add(1,1,1,0, 1,1,3);
    add(1,0,1,0, 0,0,0);
    // runs of zeros, then polarity flip breaks it
    add(1,0,0,0, 0,0,1); add(1,0,0,0, 0,0,2); add(1,0,0,0, 1,1,3);
    add(1,0,1,0, 0,0,0);
    // retrigger every RUN_LEN matches, run_cnt saturating at 7
    add(1,1,1,1, 0,0,1); add(1,1,1,1, 0,0,2); add(1,1,1,1, 1,1,3);
    add(1,1,1,1, 1,0,4); add(1,1,1,1, 1,0,5); add(1,1,1,1, 1,1,6);
    add(1,1,1,1, 1,0,7); add(1,1,1,1, 1,0,7); add(1,1,1,1, 1,1,7);
    add(1,1,1,1, 1,0,7); add(1,0,1,0, 0,0,0);
    // sample enable gaps neither break nor advance the run
    add(1,1,1,0, 0,0,1); add(0,1,1,0, 0,0,1); add(0,0,1,0, 0,0,1);
    add(1,1,1,0, 0,0,2); add(0,0,1,0, 0,0,2); add(1,1,1,0, 1,1,3);
    add(0,0,1,0, 1,0,3); add(1,0,1,0, 0,0,0);

    foreach (vecs[i]) begin
      apply(vecs[i].en, vecs[i].ina, vecs[i].pol, vecs[i].rt);
      check($sformatf("vec%0d_dataout", i), bus.dataout, vecs[i].d);
      check($sformatf("vec%0d_det", i), bus.det_pulse, vecs[i].p);
      check($sformatf("vec%0d_cnt", i), bus.run_cnt, vecs[i].c);
    end

    // asynchronous reset in the cycle right after entering HIT
    repeat (RUN_LEN) apply(1, 1, 1, 0);
    check("pre_async_det", bus.det_pulse, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_dataout", bus.dataout, 0);
    check("async_det", bus.det_pulse, 0);
    check("async_cnt", bus.run_cnt, 0);
    check("async_state", bus.state_o, 0);
    m_run = 0;
    @(negedge clk);
    rst = 1'b1;
    apply(1, 1, 1, 0);
    check("release_first_cnt", bus.run_cnt, 1);
    check("release_first_state", bus.state_o, 1);
    apply(1, 0, 1, 0);

    // retrig dropped mid-run stops further pulses from the next match on
    repeat (5) apply(1, 1, 1, 1);
    apply(1, 1, 1, 0);
    check_model("retrig_off");
    check("retrig_off_det", bus.det_pulse, 0);
    apply(1, 0, 1, 0);

`ifdef RUN_DET_STICKY_EN
    do_reset();
    check("sticky_reset", bus.sticky, 0);
    repeat (RUN_LEN) apply(1, 1, 1, 0);
    apply(1, 1, 1, 0);
    check("sticky_set", bus.sticky, 1);
    bus.sticky_clr = 1'b1;
    apply(1, 0, 1, 0);
    check("sticky_clr", bus.sticky, 0);
    repeat (RUN_LEN + 1) apply(1, 1, 1, 0);
    check("sticky_set_wins", bus.sticky, 1);
    bus.sticky_clr = 1'b0;
    apply(1, 0, 1, 0);
`endif

    do_reset();
    ina_r = 1'b1; pol_r = 1'b1; rt_r = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(99) < 20) ina_r = ~ina_r;
      if ($urandom_range(99) < 2)  pol_r = ~pol_r;
      if ($urandom_range(99) < 5)  rt_r  = ~rt_r;
      en_r = ($urandom_range(99) < 85);
      apply(en_r, ina_r, pol_r, rt_r);
      check_model($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
